// File: rtl/conv_enc_pkg.sv
// Shared types, limits and the generator XOR helper for the streaming convolutional encoder.
package conv_enc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ENC  = 2'd1,
    TAIL = 2'd2
  } enc_state_e;

  localparam int K_MAX = 9;
  localparam int N_MAX = 4;

  // Generator j sits at bits [j*K +: K]; the MSB of each generator taps the current bit.
  localparam logic [13:0] G_K7_133_171 = {7'o171, 7'o133};
  localparam logic [5:0]  G_K3_7_5     = {3'o7, 3'o5};

  function automatic logic [N_MAX-1:0] conv_sym(
    input logic [N_MAX*K_MAX-1:0] g,
    input int                     k,
    input int                     n,
    input logic                   cur_bit,
    input logic [K_MAX-2:0]       sr
  );
    logic [N_MAX-1:0] sym;
    logic [K_MAX-1:0] win;
    sym = '0;
    win = {1'b0, sr};
    win[k-1] = cur_bit;
    for (int j = 0; j < N_MAX; j++) begin
      for (int i = 0; i < K_MAX; i++) begin
        if (j < n && i < k) begin
          sym[j] = sym[j] ^ (g[j*k + i] & win[i]);
        end
      end
    end
    return sym;
  endfunction

endpackage

// File: rtl/conv_shift_core.sv
// K-1 bit encoder shift register and the N generator XOR trees over {load_bit, sr}.
module conv_shift_core
  import conv_enc_pkg::*;
#(
  parameter int           K = 7,
  parameter int           N = 2,
  parameter logic [N*K-1:0] G = G_K7_133_171
) (
  input  logic         clk,
  input  logic         load_bit,
  input  logic         advance,
  input  logic         clear,
  output logic [N-1:0] sym
);

  logic [K-2:0]           sr_q, sr_d;
  logic [K_MAX-2:0]       sr_pad;
  logic [N_MAX*K_MAX-1:0] g_pad;
  logic [N_MAX-1:0]       sym_full;
  logic                   unused_sym_hi;

  // Newest bit enters at the top so sr[K-2] is the previous input bit.
  always_comb begin
    sr_d = sr_q;
    if (clear) begin
      sr_d = '0;
    end else if (advance) begin
      sr_d = (sr_q >> 1) | ((K-1)'(load_bit) << (K-2));
    end
  end

  always_comb begin
    sr_pad = '0;
    sr_pad[K-2:0] = sr_q;
    g_pad = '0;
    g_pad[N*K-1:0] = G;
    sym_full = conv_sym(g_pad, K, N, load_bit, sr_pad);
  end

  assign sym = sym_full[N-1:0];
  assign unused_sym_hi = ^sym_full;

  always_ff @(posedge clk) begin
    sr_q <= sr_d;
  end

endmodule

// File: rtl/conv_encoder_stream.sv
// Rate-1/N convolutional encoder with valid/ready streaming and K-1 zero tail per frame.
// Optional puncturing is enabled by defining CONV_PUNCT_EN.
module conv_encoder_stream
  import conv_enc_pkg::*;
#(
  parameter int                     K         = 7,
  parameter int                     N         = 2,
  parameter logic [N*K-1:0]         G         = G_K7_133_171,
  parameter int                     DIN_W     = 8,
  parameter int                     PUNCT_P   = 3,
  parameter logic [N*PUNCT_P-1:0]   PUNCT_PAT = 6'b111011
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [DIN_W-1:0] s_data,
  input  logic             s_last,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [N-1:0]     m_data,
  output logic [N-1:0]     m_keep,
  output logic             m_last,
  output logic             busy
);

  if (K < 2 || K > K_MAX) begin : g_bad_k
    $error("conv_encoder_stream: K out of range 2..9");
  end
  if (N < 2 || N > N_MAX) begin : g_bad_n
    $error("conv_encoder_stream: N out of range 2..4");
  end
  if (DIN_W < 1 || DIN_W > 32) begin : g_bad_w
    $error("conv_encoder_stream: DIN_W out of range 1..32");
  end
  if (PUNCT_P < 1 || PUNCT_PAT == '0) begin : g_bad_punct
    $error("conv_encoder_stream: puncture period or pattern invalid");
  end

  localparam int CNT_W = (DIN_W > 1) ? $clog2(DIN_W) : 1;
  localparam int TC_W  = (K > 2) ? $clog2(K - 1) : 1;

  enc_state_e       state_q, state_d;
  logic [DIN_W-1:0] word_q, word_d;
  logic             last_q, last_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [TC_W-1:0]  tail_cnt_q, tail_cnt_d;
  logic             m_valid_q, m_valid_d;
  logic [N-1:0]     m_data_q, m_data_d;
  logic [N-1:0]     m_keep_q, m_keep_d;
  logic             m_last_q, m_last_d;
  logic             adv, last_bit, last_tail, cur_bit, emit, sym_last;
  logic [N-1:0]     sym;

`ifdef CONV_PUNCT_EN
  localparam int PH_W = (PUNCT_P > 1) ? $clog2(PUNCT_P) : 1;
  logic [PH_W-1:0] phase_q, phase_d;
  logic [N-1:0]    keep_slice;
`endif

  // Handshakes: a transfer happens on a clk edge where valid && ready; the output
  // register only changes when it is empty or its symbol is being taken (adv).
  always_comb begin
    adv       = !m_valid_q || m_ready;
    last_bit  = (bit_cnt_q == CNT_W'(DIN_W - 1));
    last_tail = (tail_cnt_q == TC_W'(K - 2));
    cur_bit   = (state_q == ENC) ? word_q[DIN_W-1] : 1'b0;
    emit      = adv && (state_q != IDLE);
    sym_last  = (state_q == TAIL) && last_tail;
    s_ready   = (state_q == IDLE) ||
                ((state_q == ENC) && adv && last_bit && !last_q);
  end

  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    last_d     = last_q;
    bit_cnt_d  = bit_cnt_q;
    tail_cnt_d = tail_cnt_q;
    case (state_q)
      IDLE: begin
        if (s_valid) begin
          word_d    = s_data;
          last_d    = s_last;
          bit_cnt_d = '0;
          state_d   = ENC;
        end
      end
      ENC: begin
        if (adv) begin
          word_d = word_q << 1;
          if (last_bit) begin
            bit_cnt_d = '0;
            if (last_q) begin
              tail_cnt_d = '0;
              state_d    = TAIL;
            end else if (s_valid) begin
              word_d = s_data;
              last_d = s_last;
            end else begin
              state_d = IDLE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
          end
        end
      end
      TAIL: begin
        if (adv) begin
          if (last_tail) begin
            state_d = IDLE;
          end else begin
            tail_cnt_d = tail_cnt_q + TC_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_keep_d  = m_keep_q;
    m_last_d  = m_last_q;
`ifdef CONV_PUNCT_EN
    phase_d    = phase_q;
    keep_slice = PUNCT_PAT[int'(phase_q)*N +: N];
`endif
    if (adv) begin
      m_valid_d = 1'b0;
      m_last_d  = 1'b0;
    end
    if (emit) begin
      m_data_d  = sym;
      m_last_d  = sym_last;
      m_valid_d = 1'b1;
`ifdef CONV_PUNCT_EN
      // The frame-final symbol is always shown in full so m_last is never punctured away.
      m_keep_d = sym_last ? {N{1'b1}} : keep_slice;
      if (!sym_last && keep_slice == '0) begin
        m_valid_d = 1'b0;
      end
      if (sym_last || phase_q == PH_W'(PUNCT_P - 1)) begin
        phase_d = '0;
      end else begin
        phase_d = phase_q + PH_W'(1);
      end
`else
      m_keep_d = {N{1'b1}};
`endif
    end
  end

  conv_shift_core #(
    .K (K),
    .N (N),
    .G (G)
  ) u_core (
    .clk      (clk),
    .load_bit (cur_bit),
    .advance  (emit),
    .clear    (!reset_n),
    .sym      (sym)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      word_q     <= '0;
      last_q     <= 1'b0;
      bit_cnt_q  <= '0;
      tail_cnt_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_keep_q   <= '0;
      m_last_q   <= 1'b0;
`ifdef CONV_PUNCT_EN
      phase_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      word_q     <= word_d;
      last_q     <= last_d;
      bit_cnt_q  <= bit_cnt_d;
      tail_cnt_q <= tail_cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
      m_keep_q   <= m_keep_d;
      m_last_q   <= m_last_d;
`ifdef CONV_PUNCT_EN
      phase_q    <= phase_d;
`endif
    end
  end

  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;
  assign m_last  = m_last_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_conv_encoder_stream.sv
// Scoreboard bench for conv_encoder_stream: K=7 rate-1/2 instance plus a K=3, 4-bit-word instance.
module tb_conv_encoder_stream;
  import conv_enc_pkg::*;

  localparam int W = 5;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic       s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [7:0] s_data = '0;
  logic       s_ready, m_valid, m_last, busy;
  logic [1:0] m_data, m_keep;

  logic       s3_valid = 1'b0, s3_last = 1'b0, m3_ready = 1'b1;
  logic [3:0] s3_data = '0;
  logic       s3_ready, m3_valid, m3_last, busy3;
  logic [1:0] m3_data, m3_keep;

  int n_checks = 0;
  int n_fail = 0;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp3_q[$];
  int cyc = 0;
  int rx7 = 0;
  int accepts = 0;
  int last_cyc = 0;
  logic bp_en = 1'b0;
`ifdef CONV_PUNCT_EN
  int ph7 = 0;
  int ph3 = 0;
  logic [5:0] pat = 6'b111011;
`endif

  conv_encoder_stream u_dut (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep),
    .m_last(m_last), .busy(busy)
  );

  conv_encoder_stream #(.K(3), .N(2), .G(G_K3_7_5), .DIN_W(4)) u_dut3 (
    .clk(clk), .reset_n(reset_n),
    .s_valid(s3_valid), .s_ready(s3_ready), .s_data(s3_data), .s_last(s3_last),
    .m_valid(m3_valid), .m_ready(m3_ready), .m_data(m3_data), .m_keep(m3_keep),
    .m_last(m3_last), .busy(busy3)
  );

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = bp_en ? (cyc % 3 == 0) : 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit d3, input logic last, input logic [1:0] data);
    logic [1:0] keep;
    keep = 2'b11;
`ifdef CONV_PUNCT_EN
    if (d3) begin
      if (!last) keep = pat[ph3*2 +: 2];
      ph3 = last ? 0 : (ph3 + 1) % 3;
    end else begin
      if (!last) keep = pat[ph7*2 +: 2];
      ph7 = last ? 0 : (ph7 + 1) % 3;
    end
`endif
    if (d3) exp3_q.push_back({last, keep, data});
    else    exp_q.push_back({last, keep, data});
  endtask

  // Hand-computed impulse response of the 171/133 code plus six zero tail symbols.
  task automatic push_impulse();
    logic [27:0] v;
    v = 28'b11_10_11_11_00_01_11_00_00_00_00_00_00_00;
    for (int i = 0; i < 14; i++) push_exp(1'b0, i == 13, v[27-2*i -: 2]);
  endtask

  task automatic model_frame(input logic [23:0] bits_in, input int nbits);
    logic [5:0] sr;
    logic [6:0] win;
    logic       b;
    sr = '0;
    for (int i = 0; i < nbits + 6; i++) begin
      b = (i < nbits) ? bits_in[23-i] : 1'b0;
      win = {b, sr};
      push_exp(1'b0, i == nbits + 5, {^(win & 7'o171), ^(win & 7'o133)});
      sr = {b, sr[5:1]};
    end
  endtask

  task automatic send_word(input logic [7:0] d, input logic l, output int acc_cyc);
    int g;
    g = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    #1;
    while (!s_ready && g < 500) begin
      @(negedge clk);
      #1;
      g++;
    end
    if (g >= 500) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: s_ready got 0, expected 1");
    end
    @(posedge clk);
    accepts++;
    @(negedge clk);
    acc_cyc = cyc;
  endtask

  task automatic wait_drain(input string name);
    int g;
    g = 0;
    while ((exp_q.size() != 0 || exp3_q.size() != 0 || busy || busy3 || m_valid || m3_valid)
           && g < 600) begin
      @(negedge clk);
      #1;
      g++;
    end
    check({name, "_drained"}, exp_q.size() + exp3_q.size(), 0);
  endtask

  logic       stall_prev = 1'b0;
  logic [5:0] held = '0;
  always @(negedge clk) begin
    if (reset_n) begin
      if (stall_prev) check("hold7", {m_valid, m_last, m_keep, m_data}, held);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected7: got %0h, expected no symbol", {m_last, m_keep, m_data});
        end else begin
          check("sym7", {m_last, m_keep, m_data}, exp_q.pop_front());
        end
        rx7++;
        if (m_last) last_cyc = cyc;
      end
      stall_prev = m_valid && !m_ready;
      held = {1'b1, m_last, m_keep, m_data};
    end else begin
      stall_prev = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (reset_n && m3_valid && m3_ready) begin
      if (exp3_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected3: got %0h, expected no symbol", {m3_last, m3_keep, m3_data});
      end else begin
        check("sym3", {m3_last, m3_keep, m3_data}, exp3_q.pop_front());
      end
    end
  end

  initial begin
    int c0, c1, c2, base, g;
    logic [11:0] v3;
    repeat (3) @(negedge clk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_m_keep", m_keep, 0);
    check("rst_m_last", m_last, 0);
    check("rst_busy", busy, 0);
    check("rst_s_ready", s_ready, 1);
    check("rst_m3_valid", m3_valid, 0);
    #1 reset_n = 1'b1;

    // Impulse response of one last word 0x80.
    push_impulse();
    send_word(8'h80, 1'b1, c0);
    s_valid = 1'b0;
    wait_drain("t1");

    // Back-to-back words with no bubbles: 30 symbols over exactly 30 cycles.
    accepts = 0;
    model_frame(24'hA53CFF, 24);
    send_word(8'hA5, 1'b0, c0);
    send_word(8'h3C, 1'b0, c1);
    send_word(8'hFF, 1'b1, c2);
    s_valid = 1'b0;
    wait_drain("t2");
    check("t2_accepts", accepts, 3);
    check("t2_reload_gap1", c1 - c0, 8);
    check("t2_reload_gap2", c2 - c1, 8);
    check("t2_span", last_cyc - c0, 30);

    // Same frame under 1-of-3 backpressure.
    bp_en = 1'b1;
    model_frame(24'hA53CFF, 24);
    send_word(8'hA5, 1'b0, c0);
    send_word(8'h3C, 1'b0, c1);
    send_word(8'hFF, 1'b1, c2);
    s_valid = 1'b0;
    wait_drain("t3");
    bp_en = 1'b0;
    repeat (2) @(negedge clk);

    // Reset in the middle of a frame, then a clean impulse frame.
    push_impulse();
    base = rx7;
    send_word(8'h80, 1'b1, c0);
    s_valid = 1'b0;
    g = 0;
    while (rx7 - base < 5 && g < 100) begin
      @(negedge clk);
      #1;
      g++;
    end
    check("t4_symbols_before_reset", rx7 - base, 5);
    reset_n = 1'b0;
    exp_q.delete();
`ifdef CONV_PUNCT_EN
    ph7 = 0;
`endif
    @(negedge clk);
    check("t4_m_valid", m_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_s_ready", s_ready, 1);
    #1 reset_n = 1'b1;
    push_impulse();
    send_word(8'h80, 1'b1, c0);
    s_valid = 1'b0;
    wait_drain("t4");

    // K=3, generators 7/5, 4-bit word 0xF.
    v3 = 12'b11_01_10_10_01_11;
    for (int i = 0; i < 6; i++) push_exp(1'b1, i == 5, v3[11-2*i -: 2]);
    s3_valid = 1'b1;
    s3_data  = 4'hF;
    s3_last  = 1'b1;
    #1;
    check("t5_s_ready", s3_ready, 1);
    @(posedge clk);
    @(negedge clk);
    s3_valid = 1'b0;
    wait_drain("t5");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_checks++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected test completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
